// File: rtl/arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter_pkg
//   Shared types and defaults for the core memory arbiter.
//   - arb_state_t : arbiter phase (RUN: cores arbitrate, DRAIN: wait for core
//                   traffic to finish, HOST: memory owned by the host port)
//   - DEF_*       : default parameter values
//   - ptr_width() : width of a core index, never less than one bit
// -----------------------------------------------------------------------------
package arbiter_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HOST  = 2'd2
   } arb_state_t;

   localparam int DEF_N_CORES = 8;
   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_DATA_W  = 16;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches the request mask starting one
//   above the pointer, wrapping around, and grants the first set bit.
//   Ports:
//     req_i  [N_CORES-1:0] request mask (already qualified by eligibility)
//     ptr_i  [PTR_W-1:0]   index of the most recently granted requester
//     gnt_o  [N_CORES-1:0] one-hot grant, zero when no request
//     idx_o  [PTR_W-1:0]   binary index of the granted bit (0 when none)
// -----------------------------------------------------------------------------
module rr_pick
   import arbiter_pkg::*;
#(
   parameter  int N_CORES = DEF_N_CORES,
   localparam int PTR_W   = ptr_width(N_CORES)
) (
   input  logic [N_CORES-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [N_CORES-1:0] gnt_o,
   output logic [PTR_W-1:0]   idx_o
);

   localparam logic [PTR_W:0] N_L = (PTR_W+1)'(N_CORES);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] cand;
   logic             found;

   // ptr_i < N_CORES and the offset is at most N_CORES, so one conditional
   // subtraction is enough to wrap the candidate index.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 1; k <= N_CORES; k++) begin
         sum  = {1'b0, ptr_i} + (PTR_W+1)'(k);
         cand = (sum >= N_L) ? PTR_W'(sum - N_L) : PTR_W'(sum);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter
//   Shares one single-port data memory between N_CORES core ports and the host
//   port. Cores arbitrate round-robin; raising host_sel drains outstanding core
//   traffic and then hands the memory to the host until host_sel falls.
//
//   Handshake: a core holds core_req and its command fields stable; the
//   transfer is accepted at the rising edge where core_req[i] & core_gnt[i].
//   core_gnt is combinational and at most one-hot. Reads return one-cycle
//   core_rvalid pulses two cycles after acceptance; writes return nothing.
//
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     n_cores                    number of enabled cores (core i eligible iff i < n_cores)
//     core_req/we/addr/wdata     per-core request (addr/wdata packed per core)
//     core_gnt                   combinational grant
//     core_rvalid, core_rdata    read return pulse and shared data
//     host_sel, host_ready       host phase request / memory owned by host
//     host_en/we/addr/wdata      host command, used only while host_ready
//     host_rdata                 host read data (memory output)
//     mem_en/we/addr/wdata       registered memory command
//     mem_rdata                  synchronous memory read data
//     dbg_state                  current arbiter phase (arb_state_t encoding)
// -----------------------------------------------------------------------------
module core_mem_arbiter
   import arbiter_pkg::*;
#(
   parameter int N_CORES = DEF_N_CORES,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [3:0]                n_cores,
   input  logic [N_CORES-1:0]        core_req,
   input  logic [N_CORES-1:0]        core_we,
   input  logic [N_CORES*ADDR_W-1:0] core_addr,
   input  logic [N_CORES*DATA_W-1:0] core_wdata,
   output logic [N_CORES-1:0]        core_gnt,
   output logic [N_CORES-1:0]        core_rvalid,
   output logic [DATA_W-1:0]         core_rdata,
   input  logic                      host_sel,
   output logic                      host_ready,
   input  logic                      host_en,
   input  logic                      host_we,
   input  logic [ADDR_W-1:0]         host_addr,
   input  logic [DATA_W-1:0]         host_wdata,
   output logic [DATA_W-1:0]         host_rdata,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic [1:0]                dbg_state
);

   localparam int PTR_W = ptr_width(N_CORES);

   arb_state_t        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              host_ready_q, host_ready_d;
   // Read tag pipeline: stage 1 lines up with mem_en, stage 2 with the
   // memory data coming back.
   logic              tag1_v_q, tag1_v_d;
   logic [PTR_W-1:0]  tag1_id_q, tag1_id_d;
   logic              tag2_v_q;
   logic [PTR_W-1:0]  tag2_id_q;

   logic [N_CORES-1:0] elig;
   logic [N_CORES-1:0] pick_gnt;
   logic [PTR_W-1:0]   pick_idx;
   logic               accept;
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;

   // n_cores above N_CORES naturally behaves as N_CORES since i < N_CORES.
   for (genvar i = 0; i < N_CORES; i++) begin : g_elig
      assign elig[i] = core_req[i] & (4'(i) < n_cores);
   end

   rr_pick #(.N_CORES(N_CORES)) u_pick (
      .req_i (elig),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   // host_sel blocks grants in the same cycle so nothing new enters the
   // pipeline once the host has asked for the memory.
   assign core_gnt = (state_q == RUN && !host_sel) ? pick_gnt : '0;
   assign accept   = |core_gnt;

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_CORES; i++) begin
         if (core_gnt[i]) begin
            sel_we    = core_we[i];
            sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = core_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      host_ready_d = host_ready_q;
      tag1_v_d     = 1'b0;
      tag1_id_d    = tag1_id_q;
      case (state_q)
         RUN: begin
            if (accept) begin
               mem_en_d    = 1'b1;
               mem_we_d    = sel_we;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_wdata;
               ptr_d       = pick_idx;
               tag1_v_d    = ~sel_we;
               tag1_id_d   = pick_idx;
            end
            if (host_sel) state_d = DRAIN;
         end
         DRAIN: begin
            // tag stage 1 is only valid with mem_en_q, so these two cover it.
            if (!mem_en_q && !tag2_v_q) begin
               state_d      = HOST;
               host_ready_d = 1'b1;
            end
         end
         HOST: begin
            mem_en_d    = host_en;
            mem_we_d    = host_we;
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
            if (!host_sel) begin
               state_d      = RUN;
               ptr_d        = PTR_W'(N_CORES-1);
               host_ready_d = 1'b0;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         ptr_q        <= PTR_W'(N_CORES-1);
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         host_ready_q <= 1'b0;
         tag1_v_q     <= 1'b0;
         tag1_id_q    <= '0;
         tag2_v_q     <= 1'b0;
         tag2_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         host_ready_q <= host_ready_d;
         tag1_v_q     <= tag1_v_d;
         tag1_id_q    <= tag1_id_d;
         tag2_v_q     <= tag1_v_q;
         tag2_id_q    <= tag1_id_q;
      end
   end

   always_comb begin
      core_rvalid = '0;
      if (tag2_v_q) core_rvalid[tag2_id_q] = 1'b1;
   end

   assign core_rdata = mem_rdata;
   assign host_rdata = mem_rdata;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign host_ready = host_ready_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;

   localparam int N  = 8;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int PH_ARB = 0, PH_LEAVE = 1, PH_OWN = 2;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0]    n_cores;
   logic [N-1:0]  core_req, core_we, core_gnt, core_rvalid;
   logic [N*AW-1:0] core_addr;
   logic [N*DW-1:0] core_wdata;
   logic [DW-1:0] core_rdata;
   logic          host_sel, host_ready, host_en, host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata, host_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [1:0]    dbg_state;

   core_mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .n_cores(n_cores),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .host_sel(host_sel), .host_ready(host_ready), .host_en(host_en), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   // Synchronous RAM attached to the memory port.
   logic [DW-1:0] ram [0:255];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[7:0]];
      end
   end

   // ---------------- scoreboard bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic          en;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } mcmd_t;
   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } ret_t;

   logic [DW-1:0] model_mem [0:255];
   logic [DW-1:0] exp_q [$];   // expected core read data, in order
   ret_t          rv_q [$];    // expected core read returns, stamped with cycle
   ret_t          hr_q [$];    // expected host read returns
   mcmd_t         cur_mem;
   int            cyc = 0;
   int            last_gnt;
   int            phase;
   logic [N-1:0]  acc_seen;

   // The grant rule: first enabled requester after the last granted core.
   function automatic logic [N-1:0] rr_expect(input logic [N-1:0] req, input logic [3:0] nc,
                                              input int last);
      int neff;
      logic [N-1:0] r;
      logic hit;
      neff = (int'(nc) > N) ? N : int'(nc);
      r = '0;
      hit = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (!hit && c < neff && req[c]) begin
            r[c] = 1'b1;
            hit = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   always @(negedge clk) begin : p_model
      logic [N-1:0]  eg, erv;
      logic [DW-1:0] ed;
      logic          busy;
      int            gi;
      logic [7:0]    a;
      mcmd_t         nxt;
      acc_seen = core_req & core_gnt;
      if (!rst_n) begin
         phase    = PH_ARB;
         last_gnt = N - 1;
         cur_mem  = '0;
         rv_q.delete();
         hr_q.delete();
         exp_q.delete();
      end else begin
         eg = '0;
         if (phase == PH_ARB && !host_sel) eg = rr_expect(core_req, n_cores, last_gnt);
         chk("core_gnt", core_gnt, eg);
         chk("mem_en", mem_en, cur_mem.en);
         if (cur_mem.en) begin
            chk("mem_we", mem_we, cur_mem.we);
            chk("mem_addr", mem_addr, cur_mem.addr);
            if (cur_mem.we) chk("mem_wdata", mem_wdata, cur_mem.wdata);
         end
         erv = '0;
         ed  = '0;
         if (rv_q.size() > 0 && rv_q[0].due == cyc) begin
            erv[rv_q[0].id] = 1'b1;
            ed = exp_q.pop_front();
            void'(rv_q.pop_front());
         end
         chk("core_rvalid", core_rvalid, erv);
         if (erv != '0) chk("core_rdata", core_rdata, ed);
         if (hr_q.size() > 0 && hr_q[0].due == cyc) begin
            chk("host_rdata", host_rdata, hr_q[0].data);
            void'(hr_q.pop_front());
         end
         chk("host_ready", host_ready, (phase == PH_OWN));
         busy = cur_mem.en || (erv != '0);

         nxt = '0;
         gi  = onehot_idx(eg);
         if (gi >= 0) begin
            nxt = {1'b1, core_we[gi], core_addr[gi*AW +: AW], core_wdata[gi*DW +: DW]};
            a = nxt.addr[7:0];
            if (nxt.we) model_mem[a] = nxt.wdata;
            else begin
               rv_q.push_back('{due: cyc + 2, id: gi, data: model_mem[a]});
               exp_q.push_back(model_mem[a]);
            end
            last_gnt = gi;
         end else if (phase == PH_OWN && host_en) begin
            nxt = {1'b1, host_we, host_addr, host_wdata};
            a = host_addr[7:0];
            if (host_we) model_mem[a] = host_wdata;
            else hr_q.push_back('{due: cyc + 2, id: 0, data: model_mem[a]});
         end
         case (phase)
            PH_ARB:   if (host_sel) phase = PH_LEAVE;
            PH_LEAVE: if (!busy) phase = PH_OWN;
            default:  if (!host_sel) begin
                         phase    = PH_ARB;
                         last_gnt = N - 1;
                      end
         endcase
         cur_mem = nxt;
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      core_req   = '0;
      core_we    = '0;
      core_addr  = '0;
      core_wdata = '0;
      host_sel   = 1'b0;
      host_en    = 1'b0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
      core_req[i] = 1'b1;
      core_we[i]  = we;
      core_addr[i*AW +: AW]  = ad;
      core_wdata[i*DW +: DW] = wd;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic core_xfer(input int i, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
      logic got;
      got = 1'b0;
      set_cmd(i, we, ad, wd);
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (core_gnt[i]) got = 1'b1;
         @(posedge clk);
         #1;
      end
      core_req[i] = 1'b0;
      if (!got) chk("xfer_timeout", 0, 1);
   endtask

   task automatic new_rand_cmd(input int i);
      set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), DW'($urandom_range(0, 65535)));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int order [8];
      int cnt_hi, cnt_any, cnt_en, lat, rv_seen;
      logic got_rdy;
      int hs_left;

      for (int i = 0; i < 256; i++) begin
         ram[i] = '0;
         model_mem[i] = '0;
      end
      mem_rdata = '0;
      n_cores = 4'd1;
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);

      // Reset values
      @(negedge clk);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_host_ready", host_ready, 0);
      chk("rst_core_rvalid", core_rvalid, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single core write then read back
      core_xfer(0, 1'b1, 16'h0010, 16'hBEEF);
      core_xfer(0, 1'b0, 16'h0010, 16'h0000);
      @(negedge clk);
      chk("single_rv_early", core_rvalid, 0);
      @(negedge clk);
      chk("single_rvalid", core_rvalid, 8'h01);
      chk("single_rdata", core_rdata, 16'hBEEF);

      // Round-robin order from reset with four requesters
      n_cores = 4'd4;
      reset_dut();
      for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, AW'(i), '0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         order[k] = onehot_idx(core_gnt);
      end
      for (int k = 0; k < 8; k++) chk($sformatf("rr_order_%0d", k), order[k], k % 4);

      // Eligibility mask
      @(posedge clk);
      #1 n_cores = 4'd2;
      cnt_hi = 0;
      cnt_any = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (core_gnt[3:2] != 2'b00) cnt_hi++;
         if (core_gnt != '0) cnt_any++;
      end
      chk("elig_high_grants", cnt_hi, 0);
      chk("elig_accepts", cnt_any, 12);
      @(posedge clk);
      #1 n_cores = 4'd0;
      cnt_any = 0;
      cnt_en = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (core_gnt != '0) cnt_any++;
         if (k > 0 && mem_en) cnt_en++;
      end
      chk("zero_cores_grants", cnt_any, 0);
      chk("zero_cores_mem_en", cnt_en, 0);

      // Host handoff with a core-1 read in flight
      n_cores = 4'd8;
      reset_dut();
      core_xfer(1, 1'b1, 16'h0020, 16'h1234);
      core_xfer(1, 1'b0, 16'h0020, 16'h0000);
      host_sel = 1'b1;
      rv_seen = 0;
      lat = 99;
      got_rdy = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (core_rvalid[1] && core_rdata == 16'h1234) rv_seen++;
         if (host_ready && !got_rdy) begin
            got_rdy = 1'b1;
            lat = k - 1;
         end
      end
      chk("handoff_rvalid", rv_seen, 1);
      chk("handoff_ready_seen", got_rdy, 1);
      chk("handoff_ready_lat_le3", (lat <= 3), 1);
      @(posedge clk);
      #1 begin
         host_en = 1'b1; host_we = 1'b1; host_addr = 16'h0040; host_wdata = 16'hCAFE;
      end
      @(posedge clk);
      #1 begin
         host_we = 1'b0; host_wdata = 16'h0000;
      end
      @(negedge clk);
      chk("host_wr_mem_en", mem_en, 1);
      chk("host_wr_mem_we", mem_we, 1);
      chk("host_wr_mem_addr", mem_addr, 16'h0040);
      chk("host_wr_mem_wdata", mem_wdata, 16'hCAFE);
      @(posedge clk);
      #1 host_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("host_rd_data", host_rdata, 16'hCAFE);

      // Return from host: core 0 before core 2
      @(posedge clk);
      #1 host_sel = 1'b0;
      @(posedge clk);
      #1 begin
         set_cmd(2, 1'b0, 16'h0002, '0);
         set_cmd(0, 1'b0, 16'h0000, '0);
      end
      @(negedge clk);
      chk("return_first_core0", core_gnt, 8'h01);
      @(negedge clk);
      chk("return_then_core2", core_gnt, 8'h04);
      @(posedge clk);
      #1 idle_inputs();

      // Asynchronous reset with a read in flight
      repeat (3) @(posedge clk);
      #1;
      core_xfer(3, 1'b0, 16'h0020, '0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_mem_en", mem_en, 0);
      chk("arst_mem_we", mem_we, 0);
      chk("arst_mem_addr", mem_addr, 0);
      chk("arst_mem_wdata", mem_wdata, 0);
      chk("arst_core_rvalid", core_rvalid, 0);
      chk("arst_host_ready", host_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rv_seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (core_rvalid != '0) rv_seen++;
      end
      chk("arst_no_rvalid", rv_seen, 0);

      // Randomized traffic with host phases and changing core counts
      reset_dut();
      n_cores = 4'd8;
      hs_left = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (core_req[i]) begin
               if (acc_seen[i]) begin
                  if ($urandom_range(0, 1) == 1) new_rand_cmd(i);
                  else core_req[i] = 1'b0;
               end else if ($urandom_range(0, 15) == 0) begin
                  core_req[i] = 1'b0;
               end
            end else if ($urandom_range(0, 3) == 0) begin
               new_rand_cmd(i);
            end
         end
         if ($urandom_range(0, 63) == 0) n_cores = 4'($urandom_range(0, 15));
         if (host_sel) begin
            if (hs_left == 0) host_sel = 1'b0;
            else hs_left--;
         end else if ($urandom_range(0, 149) == 0) begin
            host_sel = 1'b1;
            hs_left = $urandom_range(3, 30);
         end
         host_en    = 1'($urandom_range(0, 1));
         host_we    = 1'($urandom_range(0, 1));
         host_addr  = AW'($urandom_range(0, 255));
         host_wdata = DW'($urandom_range(0, 65535));
      end
      @(posedge clk);
      #1 idle_inputs();
      repeat (6) @(posedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Round-robin arbiter that shares the single-port data memory of the multi-core processor between up to `N_CORES` core ports and the host communication port. Cores issue one-word reads and writes through a valid/grant handshake. A host phase input drains in-flight core traffic, then hands the memory to the host load/dump sequencer. The block sits between the core array and the memory instance inside the processor top level.

## Interface
Parameters:
- `N_CORES`, 8: number of core ports (1..15).
- `ADDR_W`, 16: memory address width.
- `DATA_W`, 16: memory data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `n_cores`  in  4  count of enabled cores.
  - Core `i` is eligible iff `i < n_cores`.
  - Values above `N_CORES` behave as `N_CORES`.
  - 0 enables no core.
- `core_req`  in  N_CORES  per-core request valid.
- `core_we`  in  N_CORES  per-core write enable; 0 = read.
- `core_addr`  in  N_CORES*ADDR_W  packed per-core address; core `i` at `[i*ADDR_W +: ADDR_W]`.
- `core_wdata`  in  N_CORES*DATA_W  packed per-core write data.
- `core_gnt`  out  N_CORES  one-hot or zero, combinational; the transfer is accepted at the edge where `core_req[i] & core_gnt[i]`.
- `core_rvalid`  out  N_CORES  one-cycle pulse to the reading core.
- `core_rdata`  out  DATA_W  shared read data, valid when any `core_rvalid` bit is high.
- `host_sel`  in  1  host phase request.
- `host_ready`  out  1  memory owned by the host.
- `host_en`  in  1  host memory access this cycle.
- `host_we`  in  1  host write enable.
- `host_addr`  in  ADDR_W  host address.
- `host_wdata`  in  DATA_W  host write data.
- `host_rdata`  out  DATA_W  equals `mem_rdata`.
- `mem_en`  out  1  registered memory enable.
- `mem_we`  out  1  registered memory write enable.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_wdata`  out  DATA_W  registered memory write data.
- `mem_rdata`  in  DATA_W  synchronous RAM output, valid one cycle after `mem_en` with `mem_we=0`.

## Operation
- FSM states: RUN, DRAIN, HOST.
- RUN:
  - `core_gnt` selects the first eligible requester, searching from `ptr+1` upward with wrap-around.
  - On an accepted transfer: register the command onto `mem_*` and set `ptr` to the granted index.
  - With no accept, `mem_en` = 0; `ptr` holds.
  - Moves to DRAIN when `host_sel`=1; `core_gnt` is forced to 0 in the same cycle.
- DRAIN:
  - No grants.
  - Moves to HOST once the read-return pipeline is empty, i.e. no command in the `mem_en` stage or the `rvalid` stage.
- HOST:
  - `host_ready`=1.
  - `mem_*` are registered copies of `host_*`; `host_en` maps to `mem_en`.
  - Moves to RUN when `host_sel`=0; at the same edge `ptr` is set to `N_CORES-1` (core 0 first) and `host_ready` clears.
- Read return: a 2-entry tag pipeline `{valid, id}` tracks core reads.
  - `core_rvalid[id]` pulses in the cycle `mem_rdata` is valid.
  - `core_rdata` = `mem_rdata`.
- Writes produce no `core_rvalid`.
- Reset values:
  - state RUN; `ptr` = `N_CORES-1`; pipeline empty.
  - `mem_en`, `mem_we`, `host_ready`, `core_rvalid` all 0.
  - `mem_addr` and `mem_wdata` 0.

## Timing
- Accept at edge E. `mem_en` is high in cycle E+1. For a read, `core_rvalid` and data are valid in cycle E+2.
- One accepted transfer per cycle maximum, giving full throughput under back-to-back requests.
- Fairness: a continuously requesting eligible core is granted within `n_cores` accepts.
- `core_req` and the command fields must stay stable until accepted; dropping `req` before grant is legal and cancels the request.
- `host_sel` rising with a read accepted in the same cycle:
  - That accept is suppressed because the grant is forced to 0.
  - Reads accepted earlier still return.
  - `host_ready` asserts no more than 3 cycles after `host_sel` rises.
- `host_en` while `host_ready`=0 is ignored.
- Asynchronous reset mid-transfer:
  - In-flight read returns are discarded with no `rvalid`.
  - `mem_en` drops immediately.

## Structure
- Package `arbiter_pkg`: state enum `arb_state_t` (RUN, DRAIN, HOST) and the default width constants.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: request mask, pointer. Output: one-hot grant.
  - Parameterized by `N_CORES`.

## Test plan
- Single core: `n_cores`=1. Core 0 writes `0x0010`←`0xBEEF` and then reads `0x0010` → `core_rvalid[0]` two cycles after the read accept, with `core_rdata`=`0xBEEF`.
- Round-robin: `n_cores`=4, cores 0–3 requesting continuously from reset → grant order 0,1,2,3,0,…, one accept per cycle.
- Eligibility mask: `n_cores`=2 with cores 0–3 requesting → only cores 0 and 1 are ever granted. `n_cores`=0 → no grants and `mem_en` stays 0.
- Host handoff: `host_sel` rises one cycle after a core-1 read is accepted → core-1 `rvalid` is delivered, `host_ready` rises within 3 cycles, and host writes appear on `mem_*` one cycle later.
- Return from host: `host_sel` falls, then cores 2 and 0 request → core 0 is granted first.
- Reset: `rst_n` asserted while a read is in flight → all outputs take their reset values immediately and no `rvalid` appears after release.
